cmd_sched: RTL and testbench
============================

# cmd_sched

Two-channel scheduler that shares one `cmd_pro` command processor between two independent requesters. It performs four steps for each job:
- Arbitrates round-robin between the two requesters.
- Serializes the granted job's three-byte frame (command, A, B) onto the processor's byte input.
- Waits for the processor's result strobe, bounded by a timeout.
- Returns the 8-bit result, or an error, to the requester that owns the job.

It sits between the command sources (e.g. the UART receive path and a local sequencer) and `cmd_pro`.

## Interface
- `TIMEOUT`, 64: maximum cycles spent in WAIT before an error is declared; legal range 8..255.
- `clk` input 1: single clock, all logic on rising edge.
- `res` input 1: reset is synchronous and active-low.
- `req0`, `req1` input 1: job request per channel; held high with operands stable until the matching ack.
- `cmd0`, `a0`, `b0`, `cmd1`, `a1`, `b1` input 8 each: command byte and operands per channel.
- `ack0`, `ack1` output 1: one-cycle pulse when the channel is granted; operands are latched at that edge.
- `done0`, `done1` output 1: one-cycle pulse when the job completes, successfully or by timeout.
- `err0`, `err1` output 1: one-cycle pulse coincident with done on timeout.
- `result0`, `result1` output 8: per-channel result register, updated only at that channel's done.
- `din_pro` output 8: byte to processor.
- `en_din_pro` output 1: byte valid to processor.
- `dout_pro` input 8: processor result.
- `en_dout_pro` input 1: processor result strobe.
- `busy` output 1: high in every state except IDLE.

## Operation
- **States:** IDLE, S_CMD, S_A, S_B, WAIT. Encoding is 3-bit; unused codes go to IDLE with all strobes 0.
- **IDLE:**
  - Nothing sent: `din_pro` = 0, `en_din_pro` = 0.
  - If exactly one req is high, grant it.
  - If both are high, grant the channel not granted last. `last` resets to channel 1, so channel 0 wins the first tie.
  - On grant:
    - pulse ackN;
    - latch cmd/a/b and owner id;
    - update `last`;
    - drive `din_pro` = cmd and `en_din_pro` = 1;
    - go to S_CMD.
- **S_CMD:** drive `din_pro` = A, `en_din_pro` = 1, go to S_A.
- **S_A:** drive `din_pro` = B, `en_din_pro` = 1, go to S_B.
- **S_B:** drive `din_pro` = 0, `en_din_pro` = 0, clear the timeout counter, go to WAIT.
- **WAIT:**
  - The counter increments each cycle.
  - If `en_dout_pro` is sampled high: `result[owner]` ← `dout_pro`, pulse `done[owner]`, go to IDLE.
  - Else, if counter = `TIMEOUT`−1: `result[owner]` ← 0x00, pulse `done[owner]` and `err[owner]`, go to IDLE.
  - If the strobe and the timeout land on the same edge, the strobe wins (no error).
- **Ignored inputs:**
  - `en_dout_pro` is ignored outside WAIT.
  - The req of the non-owning channel is ignored until IDLE.
- **Requester rules:**
  - Command bytes are passed through unchecked; `cmd_pro` decodes them.
  - A requester that keeps req high after done is re-eligible; round-robin prevents starvation.
- **Reset:** with `res` low at a clock edge, the following go to 0 (idle): state, all ack/done/err strobes, `result0`, `result1`, `din_pro`, `en_din_pro`, `busy`, and the counter. `last` goes to 1. A reset mid-job abandons the job with no done pulse.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- **Grant edge g (IDLE samples req high):** ack is high for the cycle after g; cmd is on `din_pro` for the cycle after g.
- **Byte sampling by `cmd_pro`:** cmd at g+1, A at g+2, B at g+3. `en_din_pro` is high for exactly 3 consecutive cycles.
- **Result strobe:** with the serial side idle (`rdy` = 0), `cmd_pro` raises `en_dout_pro` after g+5. The scheduler samples it at g+6, and done/result are valid in the cycle after g+6.
  - Nominal grant-to-done latency: 6 clocks.
- **Back-to-back jobs:** the next grant can occur at g+7, giving a 7-clock job period.
- **Timeout:** done/err are asserted at edge g+3+`TIMEOUT` when no strobe arrives.

## Test plan
- **Reset values:** hold res low for 3 cycles → all outputs 0 and `busy` = 0. Then `req0` with cmd 0x0a, a 0x12, b 0x34:
  - `ack0` pulses;
  - `din_pro` sequence is 0x0a, 0x12, 0x34;
  - `done0` is 6 cycles after grant with `result0` = 0x46.
- **Simultaneous requests:** `req0` = `req1` = 1 with ch0 0x0b/0x50/0x20 and ch1 0x0c/0xf0/0x3c:
  - ch0 is served first, `result0` = 0x30;
  - ch1 is granted at the next IDLE, `result1` = 0x30;
  - then a second tie grants ch0.
- **Fairness:** `req0` and `req1` held high continuously for 6 jobs → grants alternate 0,1,0,1,0,1 with a 7-cycle period.
- **Timeout:** processor `rdy` held at 1 (`en_dout_pro` never asserted) → `done0` and `err0` at g+3+64, `result0` = 0x00, `busy` drops the next cycle.
- **Strobe/timeout race:** force `en_dout_pro` exactly at the timeout edge → done without err, and result = `dout_pro`.
- **Mid-job reset:** assert res low while in WAIT → next cycle `busy` = 0 with no done pulse. A following `req1` job with cmd 0x0d, a 0xa0, b 0x05 → `result1` = 0xa5.

Source files
------------

// File: rtl/cmd_sched.sv
// Two-requester round-robin front end for cmd_pro: grants one job at a time,
// streams its cmd/A/B bytes, then waits (bounded) for the result strobe.
module cmd_sched #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       res,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] cmd0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] cmd1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] result0,
  output logic [7:0] result1,
  output logic [7:0] din_pro,
  output logic       en_din_pro,
  input  logic [7:0] dout_pro,
  input  logic       en_dout_pro,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Handshake: a requester raises reqN with cmd/a/b stable and holds them until
  // the one-cycle ackN; operands are captured on the grant edge, and the job
  // later closes with exactly one doneN pulse (errN alongside it on timeout).

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_CMD = 3'd1,
    S_A   = 3'd2,
    S_B   = 3'd3,
    WAIT  = 3'd4
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic       last_q;
  logic       owner_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] cnt_q;
  logic       ack0_q, ack1_q;
  logic       done0_q, done1_q;
  logic       err0_q, err1_q;
  logic [7:0] result0_q, result1_q;
  logic [7:0] din_q;
  logic       en_din_q;
  logic       busy_q;

  logic       gnt_valid_d;
  logic       gnt_ch_d;
  logic [7:0] cmd_sel_d;
  logic [7:0] a_sel_d;
  logic [7:0] b_sel_d;

  // On a tie the channel that was not granted last wins.
  always_comb begin
    gnt_valid_d = req0 | req1;
    gnt_ch_d    = 1'b0;
    if (req0 && req1) gnt_ch_d = ~last_q;
    else if (req1)    gnt_ch_d = 1'b1;
    cmd_sel_d = gnt_ch_d ? cmd1 : cmd0;
    a_sel_d   = gnt_ch_d ? a1   : a0;
    b_sel_d   = gnt_ch_d ? b1   : b0;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      cnt_q     <= 8'h00;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      result0_q <= 8'h00;
      result1_q <= 8'h00;
      din_q     <= 8'h00;
      en_din_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          din_q    <= 8'h00;
          en_din_q <= 1'b0;
          busy_q   <= 1'b0;
          if (gnt_valid_d) begin
            ack0_q   <= ~gnt_ch_d;
            ack1_q   <= gnt_ch_d;
            owner_q  <= gnt_ch_d;
            last_q   <= gnt_ch_d;
            a_q      <= a_sel_d;
            b_q      <= b_sel_d;
            din_q    <= cmd_sel_d;
            en_din_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_CMD;
          end
        end
        S_CMD: begin
          din_q    <= a_q;
          en_din_q <= 1'b1;
          state_q  <= S_A;
        end
        S_A: begin
          din_q    <= b_q;
          en_din_q <= 1'b1;
          state_q  <= S_B;
        end
        S_B: begin
          din_q    <= 8'h00;
          en_din_q <= 1'b0;
          cnt_q    <= 8'h00;
          state_q  <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          // The strobe is checked first so it wins a same-edge race with the timeout.
          if (en_dout_pro) begin
            if (owner_q) begin
              result1_q <= dout_pro;
              done1_q   <= 1'b1;
            end else begin
              result0_q <= dout_pro;
              done0_q   <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == LAST_CNT) begin
            if (owner_q) begin
              result1_q <= 8'h00;
              done1_q   <= 1'b1;
              err1_q    <= 1'b1;
            end else begin
              result0_q <= 8'h00;
              done0_q   <= 1'b1;
              err0_q    <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          din_q    <= 8'h00;
          en_din_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign result0    = result0_q;
  assign result1    = result1_q;
  assign din_pro    = din_q;
  assign en_din_pro = en_din_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched with a small cmd_pro stand-in (add/sub/and/or)
// answering three cycles after the B byte unless proc_rdy holds it off.
module tb_cmd_sched;

  logic       clk, res;
  logic       req0, req1;
  logic [7:0] cmd0, a0, b0, cmd1, a1, b1;
  logic       ack0, ack1, done0, done1, err0, err1;
  logic [7:0] result0, result1, din_pro, dout_pro;
  logic       en_din_pro, en_dout_pro, busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       proc_rdy;
  logic       model_en, man_en;
  logic [7:0] model_dout, man_dout;
  logic [7:0] m_buf [0:2];
  logic [7:0] m_res;
  int         m_cnt, m_pend;

  int         g_ch[$], g_cyc[$], d_ch[$], d_cyc[$], din_cyc[$];
  logic       d_err[$];
  logic [7:0] d_res[$], din_q[$];

  assign en_dout_pro = model_en | man_en;
  assign dout_pro    = man_en ? man_dout : model_dout;

  cmd_sched #(.TIMEOUT(64)) dut (
    .clk(clk), .res(res), .req0(req0), .req1(req1),
    .cmd0(cmd0), .a0(a0), .b0(b0), .cmd1(cmd1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .result0(result0), .result1(result1),
    .din_pro(din_pro), .en_din_pro(en_din_pro),
    .dout_pro(dout_pro), .en_dout_pro(en_dout_pro),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y);
    case (c)
      8'h0a:   return x + y;
      8'h0b:   return x - y;
      8'h0c:   return x & y;
      8'h0d:   return x | y;
      default: return 8'h00;
    endcase
  endfunction

  // processor stand-in
  initial begin
    model_en = 1'b0;
    model_dout = 8'h00;
    m_cnt = 0;
    m_pend = 0;
    forever begin
      @(negedge clk);
      if (!res) begin
        m_cnt = 0;
        m_pend = 0;
        model_en = 1'b0;
      end else begin
        model_en = 1'b0;
        if (m_pend > 0) begin
          m_pend = m_pend - 1;
          if (m_pend == 0 && !proc_rdy) begin
            model_en = 1'b1;
            model_dout = m_res;
          end
        end
        if (en_din_pro) begin
          m_buf[m_cnt] = din_pro;
          m_cnt = m_cnt + 1;
          if (m_cnt == 3) begin
            m_cnt = 0;
            m_pend = 3;
            m_res = alu(m_buf[0], m_buf[1], m_buf[2]);
          end
        end
      end
    end
  end

  // event monitor
  initial begin
    forever begin
      @(negedge clk);
      if (ack0) begin g_ch.push_back(0); g_cyc.push_back(cyc); end
      if (ack1) begin g_ch.push_back(1); g_cyc.push_back(cyc); end
      if (done0) begin
        d_ch.push_back(0); d_cyc.push_back(cyc); d_err.push_back(err0); d_res.push_back(result0);
      end
      if (done1) begin
        d_ch.push_back(1); d_cyc.push_back(cyc); d_err.push_back(err1); d_res.push_back(result1);
      end
      if (en_din_pro) begin din_q.push_back(din_pro); din_cyc.push_back(cyc); end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not end in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_ch.delete(); g_cyc.delete(); d_ch.delete(); d_cyc.delete();
    d_err.delete(); d_res.delete(); din_q.delete(); din_cyc.delete();
  endtask

  task automatic reset_dut();
    res = 1'b0;
    step();
    step();
    res = 1'b1;
    step();
  endtask

  task automatic wait_jobs(input int n_grant, input int n_done, input int budget,
                           input bit drop, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (drop) begin
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
      end
      if (g_ch.size() >= n_grant && d_ch.size() >= n_done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    res = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cmd0 = 8'h00; a0 = 8'h00; b0 = 8'h00; cmd1 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    proc_rdy = 1'b0; man_en = 1'b0; man_dout = 8'h00;
    repeat (3) step();
    checks++;
    if ({ack0, ack1, done0, done1, err0, err1, en_din_pro, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 00000000",
               {ack0, ack1, done0, done1, err0, err1, en_din_pro, busy});
    end
    checks++;
    if (result0 !== 8'h00) begin errors++; $display("FAIL reset_result0 got %h exp 00", result0); end
    checks++;
    if (result1 !== 8'h00) begin errors++; $display("FAIL reset_result1 got %h exp 00", result1); end
    checks++;
    if (din_pro !== 8'h00) begin errors++; $display("FAIL reset_din_pro got %h exp 00", din_pro); end
    res = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit to;
    clear_logs();
    cmd0 = 8'h0a; a0 = 8'h12; b0 = 8'h34; req0 = 1'b1;
    wait_jobs(1, 1, 40, 1'b1, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0d exp 0", to); end
    else begin
      checks++;
      if (g_ch[0] !== 0) begin errors++; $display("FAIL basic_grant_ch got %0d exp 0", g_ch[0]); end
      checks++;
      if (din_q.size() !== 3) begin errors++; $display("FAIL basic_byte_count got %0d exp 3", din_q.size()); end
      else begin
        checks++;
        if ({din_q[0], din_q[1], din_q[2]} !== 24'h0a1234) begin
          errors++; $display("FAIL basic_bytes got %h%h%h exp 0a1234", din_q[0], din_q[1], din_q[2]);
        end
        checks++;
        if (din_cyc[0] !== g_cyc[0] || din_cyc[2] !== g_cyc[0] + 2) begin
          errors++; $display("FAIL basic_byte_timing got %0d..%0d exp %0d..%0d",
                             din_cyc[0], din_cyc[2], g_cyc[0], g_cyc[0] + 2);
        end
      end
      checks++;
      if (d_cyc[0] - g_cyc[0] !== 6) begin
        errors++; $display("FAIL basic_latency got %0d exp 6", d_cyc[0] - g_cyc[0]);
      end
      checks++;
      if (d_res[0] !== 8'h46 || d_err[0] !== 1'b0) begin
        errors++; $display("FAIL basic_result got %h err %b exp 46 err 0", d_res[0], d_err[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit to;
    reset_dut();
    clear_logs();
    cmd0 = 8'h0b; a0 = 8'h50; b0 = 8'h20; cmd1 = 8'h0c; a1 = 8'hf0; b1 = 8'h3c;
    req0 = 1'b1; req1 = 1'b1;
    wait_jobs(2, 2, 60, 1'b1, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL tie_timeout got %0d exp 0", to); end
    else begin
      checks++;
      if (g_ch[0] !== 0 || g_ch[1] !== 1) begin
        errors++; $display("FAIL tie_order got %0d,%0d exp 0,1", g_ch[0], g_ch[1]);
      end
      checks++;
      if (g_cyc[1] - g_cyc[0] !== 7) begin
        errors++; $display("FAIL tie_period got %0d exp 7", g_cyc[1] - g_cyc[0]);
      end
      checks++;
      if (result0 !== 8'h30) begin errors++; $display("FAIL tie_result0 got %h exp 30", result0); end
      checks++;
      if (result1 !== 8'h30) begin errors++; $display("FAIL tie_result1 got %h exp 30", result1); end
    end
    clear_logs();
    cmd0 = 8'h0a; a0 = 8'h01; b0 = 8'h01; cmd1 = 8'h0a; a1 = 8'h02; b1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    wait_jobs(2, 2, 60, 1'b1, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL tie2_timeout got %0d exp 0", to); end
    else begin
      checks++;
      if (g_ch[0] !== 0) begin errors++; $display("FAIL tie2_first got %0d exp 0", g_ch[0]); end
      checks++;
      if (result0 !== 8'h02 || result1 !== 8'h04) begin
        errors++; $display("FAIL tie2_results got %h/%h exp 02/04", result0, result1);
      end
    end
  endtask

  task automatic test_fairness();
    bit to, to2;
    clear_logs();
    cmd0 = 8'h0a; a0 = 8'h01; b0 = 8'h02; cmd1 = 8'h0d; a1 = 8'h30; b1 = 8'h03;
    req0 = 1'b1; req1 = 1'b1;
    wait_jobs(6, 0, 80, 1'b0, to);
    req0 = 1'b0; req1 = 1'b0;
    wait_jobs(6, 6, 40, 1'b0, to2);
    checks++;
    if (to !== 1'b0 || to2 !== 1'b0) begin
      errors++; $display("FAIL fair_timeout got %0d/%0d exp 0/0", to, to2);
    end else begin
      checks++;
      if (g_ch.size() !== 6) begin errors++; $display("FAIL fair_grant_count got %0d exp 6", g_ch.size()); end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (g_ch[i] !== i % 2 || d_ch[i] !== i % 2) begin
          errors++; $display("FAIL fair_order[%0d] got g%0d d%0d exp %0d", i, g_ch[i], d_ch[i], i % 2);
        end
        checks++;
        if (d_res[i] !== ((i % 2 == 1) ? 8'h33 : 8'h03)) begin
          errors++; $display("FAIL fair_result[%0d] got %h exp %h", i, d_res[i],
                             (i % 2 == 1) ? 8'h33 : 8'h03);
        end
        if (i > 0) begin
          checks++;
          if (g_cyc[i] - g_cyc[i-1] !== 7) begin
            errors++; $display("FAIL fair_period[%0d] got %0d exp 7", i, g_cyc[i] - g_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit to;
    clear_logs();
    proc_rdy = 1'b1;
    cmd0 = 8'h0a; a0 = 8'h11; b0 = 8'h22; req0 = 1'b1;
    wait_jobs(1, 1, 120, 1'b1, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL tmo_timeout got %0d exp 0", to); end
    else begin
      checks++;
      if (d_cyc[0] - g_cyc[0] !== 67) begin
        errors++; $display("FAIL tmo_latency got %0d exp 67", d_cyc[0] - g_cyc[0]);
      end
      checks++;
      if (d_ch[0] !== 0 || d_err[0] !== 1'b1 || d_res[0] !== 8'h00) begin
        errors++; $display("FAIL tmo_done got ch%0d err %b res %h exp ch0 err 1 res 00",
                           d_ch[0], d_err[0], d_res[0]);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b exp 0", busy); end
  endtask

  task automatic test_race();
    bit to;
    int g;
    clear_logs();
    proc_rdy = 1'b1;
    cmd1 = 8'h0a; a1 = 8'h01; b1 = 8'h01; req1 = 1'b1;
    wait_jobs(1, 0, 20, 1'b1, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL race_ack got timeout %0d exp 0", to); end
    else begin
      g = g_cyc[0];
      for (int i = 0; i < 100 && cyc < g + 66; i++) step();
      checks++;
      if (d_ch.size() !== 0 || cyc !== g + 66) begin
        errors++; $display("FAIL race_early_done got done %0d at cyc %0d exp 0 at %0d",
                           d_ch.size(), cyc, g + 66);
      end
      man_dout = 8'h5a;
      man_en = 1'b1;
      step();
      man_en = 1'b0;
      checks++;
      if (done1 !== 1'b1 || err1 !== 1'b0 || result1 !== 8'h5a) begin
        errors++; $display("FAIL race_done got done %b err %b res %h exp done 1 err 0 res 5a",
                           done1, err1, result1);
      end
    end
    step();
  endtask

  task automatic test_midjob_reset();
    bit to;
    clear_logs();
    proc_rdy = 1'b1;
    cmd0 = 8'h0a; a0 = 8'h01; b0 = 8'h01; req0 = 1'b1;
    wait_jobs(1, 0, 20, 1'b1, to);
    repeat (6) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    res = 1'b0;
    step();
    res = 1'b1;
    checks++;
    if (busy !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin
      errors++; $display("FAIL mid_after_reset got busy %b done %b err %b exp 0 0 0", busy, done0, err0);
    end
    repeat (3) step();
    checks++;
    if (d_ch.size() !== 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", d_ch.size()); end
    clear_logs();
    proc_rdy = 1'b0;
    cmd1 = 8'h0d; a1 = 8'ha0; b1 = 8'h05; req1 = 1'b1;
    wait_jobs(1, 1, 40, 1'b1, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL mid_job_timeout got %0d exp 0", to); end
    else begin
      checks++;
      if (d_ch[0] !== 1 || d_err[0] !== 1'b0 || result1 !== 8'ha5) begin
        errors++; $display("FAIL mid_job_result got ch%0d err %b res %h exp ch1 err 0 res a5",
                           d_ch[0], d_err[0], result1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_race();
    test_midjob_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
